// File: rtl/btn_updown_counter.sv
// Button-driven up/down counter for the 7-segment display path.
// Two raw active-low push buttons are synchronised and debounced. Each
// press gives one step, and holding a button auto-repeats. The count is
// bounded to [MIN, MAX], either wrapping or saturating at the limits, and
// can be overwritten through a clamped synchronous load.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no single button held; waits for exactly one press
// HOLD   | one button held; timer runs towards the first auto-repeat
// REPEAT | still held; a step is issued every REPEAT_PERIOD cycles
module btn_updown_counter #(
    parameter int               WIDTH         = 16,
    parameter logic [WIDTH-1:0] INIT          = 16'h05EC,
    parameter logic [WIDTH-1:0] MIN           = '0,
    parameter logic [WIDTH-1:0] MAX           = {WIDTH{1'b1}},
    parameter bit               WRAP          = 1'b1,
    parameter int               DEB_CYCLES    = 500000,
    parameter int               REPEAT_DELAY  = 25000000,
    parameter int               REPEAT_PERIOD = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             step_up,
    output logic             step_down,
    output logic             at_max,
    output logic             at_min
);

    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] RD_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RP_LAST  = TMR_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    // Index 0 carries the up button, index 1 the down button.
    logic             rst_n;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [DEB_W-1:0] deb_cnt [2];

    logic [1:0]       state, state_nxt;
    logic             held_down, dir_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             req, req_up, req_dn;
    logic             press_up, press_dn, held_ok;

    // Internal reset: asserts immediately, releases on the next clk edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_n <= 1'b0;
        else        rst_n <= 1'b1;
    end

    // Two-flop synchronisers for the asynchronous buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {btn_down, btn_up};
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb        <= '1;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    assign press_up = ~deb[0];
    assign press_dn = ~deb[1];
    // The hold survives only while the held button is the sole one pressed.
    assign held_ok  = held_down ? (press_dn & ~press_up) : (press_up & ~press_dn);

    // Step FSM next state, repeat timer and step request
    always_comb begin
        state_nxt = state;
        timer_nxt = timer + TMR_W'(1);
        dir_nxt   = held_down;
        req       = 1'b0;
        case (state)
            S_IDLE: begin
                timer_nxt = '0;
                if (press_up ^ press_dn) begin
                    state_nxt = S_HOLD;
                    dir_nxt   = press_dn;
                    req       = 1'b1;
                end
            end
            S_HOLD: begin
                if (!held_ok) begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end else if (timer == RD_LAST) begin
                    state_nxt = S_REPEAT;
                    timer_nxt = '0;
                    req       = 1'b1;
                end
            end
            S_REPEAT: begin
                if (!held_ok) begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end else if (timer == RP_LAST) begin
                    timer_nxt = '0;
                    req       = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
            end
        endcase
        req_up = req & ~dir_nxt;
        req_dn = req & dir_nxt;
    end

    // Step FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            held_down <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            held_down <= dir_nxt;
        end
    end

    // Counter: a load wins over a step, and a saturated step gives no pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= INIT;
            step_up   <= 1'b0;
            step_down <= 1'b0;
        end else begin
            step_up   <= 1'b0;
            step_down <= 1'b0;
            if (load) begin
                if (load_value <= MIN)      count <= MIN;
                else if (load_value >= MAX) count <= MAX;
                else                        count <= load_value;
            end else if (req_up) begin
                if (count == MAX) begin
                    if (WRAP) begin
                        count   <= MIN;
                        step_up <= 1'b1;
                    end
                end else begin
                    count   <= count + WIDTH'(1);
                    step_up <= 1'b1;
                end
            end else if (req_dn) begin
                if (count == MIN) begin
                    if (WRAP) begin
                        count     <= MAX;
                        step_down <= 1'b1;
                    end
                end else begin
                    count     <= count - WIDTH'(1);
                    step_down <= 1'b1;
                end
            end
        end
    end

    assign at_max = (count == MAX);
    assign at_min = (count == MIN);

endmodule

// File: doc/btn_updown_counter.md
Name: btn_updown_counter

Overview:
- Parametrised successor to the board-level button up/down counter that feeds the 7-segment display.
- Takes two raw active-low push buttons (up, down) and applies synchronisation and debounce to each.
- Generates one step per press, plus press-and-hold auto-repeat.
- Maintains a WIDTH-bit value bounded to [MIN, MAX], with wrap or saturate mode and a synchronous load path.

Parameters:
- WIDTH, 16, counter width in bits.
- INIT, 16'h05EC, count value after reset; must lie in [MIN, MAX].
- MIN, 0, lowest legal count.
- MAX, 2**WIDTH-1, highest legal count; MIN < MAX required.
- WRAP, 1, 1: wrap at limits; 0: saturate at limits.
- DEB_CYCLES, 500000, consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles from the first step of a hold to the first auto-repeat step (500 ms).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps (100 ms).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low (0: asserted, 1: released).
- btn_up  input  1  raw button, 0: pushed, 1: released; asynchronous to clk.
- btn_down  input  1  raw button, 0: pushed, 1: released; asynchronous to clk.
- load  input  1  synchronous load strobe, active high.
- load_value  input  WIDTH  value captured on load.
- count  output  WIDTH  current counter value.
- step_up  output  1  one-cycle pulse in the cycle count increments.
- step_down  output  1  one-cycle pulse in the cycle count decrements.
- at_max  output  1  count == MAX (combinational from count).
- at_min  output  1  count == MIN (combinational from count).

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - count = INIT; step_up = step_down = 0;
  - synchronisers and debounced levels = released;
  - debounce counters and repeat timer = 0; FSM = IDLE.
- Release of reset is synchronised internally; the first active edge is the second clk edge after reset rises.
- Input sync: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - The debounced level changes on the edge where the synchronised level has differed from it for DEB_CYCLES consecutive cycles.
  - Any matching sample clears the counter.
  - Pressed = debounced level 0.
- Step FSM states: IDLE, HOLD, REPEAT.
  - IDLE -> HOLD when exactly one button is pressed. This issues an immediate step (same edge) and clears the timer.
  - HOLD: the timer counts. At timer == REPEAT_DELAY-1, issue a step, clear the timer and go to REPEAT.
  - REPEAT: at timer == REPEAT_PERIOD-1, issue a step and clear the timer.
  - HOLD/REPEAT -> IDLE, with no step, when the held button releases or the other button becomes pressed.
  - Both buttons pressed: remain in IDLE with no steps. Releasing one of them leaves exactly one pressed, which counts as a new press (immediate step).
- Latency: a clean raw press produces its first step and count change exactly 2 + DEB_CYCLES + 1 clk edges after the raw falling edge.
- Arithmetic:
  - up: count == MAX -> (WRAP ? MIN : MAX), otherwise count + 1.
  - down: count == MIN -> (WRAP ? MAX : MIN), otherwise count - 1.
  - In saturate mode, a step at the limit leaves count unchanged and does not assert step_up/step_down. FSM timing continues.
- Load:
  - count <= load_value, clamped: < MIN -> MIN, > MAX -> MAX.
  - Load takes priority over a step in the same cycle. That step is discarded (no pulse), and FSM and timer advance normally.
- The step pulses are registered and coincide with the edge on which count changes.
- Reset mid-hold: FSM returns to IDLE. A button still physically held after release of reset is re-debounced and then produces a fresh first step.

Test Plan:
Bench parameters: WIDTH=4, INIT=5, MIN=2, MAX=9, DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, WRAP=1 unless stated.
- Single clean press of btn_up, held 10 cycles:
  - count 5 -> 6 exactly 7 edges after the raw falling edge;
  - step_up high for exactly 1 cycle;
  - no further change; release gives no step.
- Bounce: btn_down toggled every 2 cycles for 12 cycles, then held low:
  - no step during bouncing;
  - exactly one decrement (5 -> 4) after 4 stable cycles + 3.
- Hold btn_up for 60 cycles past the first step, from count 7:
  - steps at +0, +20, +25, +30, ... ;
  - count sequence 8, 9, 2, 3, ...; at_max high while count 9.
- WRAP=0 from count 8, hold btn_up:
  - 8 -> 9, then count stays 9;
  - step_up never pulses again; at_max = 1.
- Both buttons pressed together: no step. Then release btn_down: one immediate increment.
- Load and reset:
  - load_value=15 gives count = 9 (clamp); load_value=0 gives 2;
  - load coincident with a repeat step gives count = load value with no step pulse;
  - reset=0 during REPEAT gives count = 5 immediately (asynchronous) and pulses 0.
